gray_rx: RTL and testbench

Receive-side companion to the team's gray-code counter. It samples a gray-coded count bus when strobed, decodes it back to binary, and checks that every sampled value is either unchanged or exactly one forward step from the previous one. It reports a sticky wrap flag and a sticky sequence-error flag. It sits at the consuming end of any link that carries a gray-coded counter value across a boundary.

---
 rtl/gray_pkg.sv | 26 ++
 rtl/gray2bin.sv | 17 +
 rtl/gray_rx.sv | 116 +++++++++++
 tb/tb_gray_rx.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the gray-code counter link: default width, receiver
// state encoding and the one gray-to-binary decode used by every consumer.
package gray_pkg;

    localparam int unsigned GRAY_WIDTH = 3;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        ERR   = 2'd2
    } rx_state_t;

    // Prefix XOR from the MSB down: bin[i] = ^g[MSB:i]. Upper zero bits of a
    // narrower zero-extended value leave the low bits unaffected.
    function automatic logic [31:0] gray_to_bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        b = b ^ (b >> 1);
        b = b ^ (b >> 2);
        b = b ^ (b >> 4);
        b = b ^ (b >> 8);
        b = b ^ (b >> 16);
        return b;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational gray-to-binary decoder.
//   gray : gray-coded input, WIDTH bits
//   bin  : binary decode, WIDTH bits
module gray2bin
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_WIDTH
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = WIDTH'(gray_to_bin(32'(gray)));
    end

endmodule

// File: rtl/gray_rx.sv
// Gray-coded counter receiver: samples Gray on En, decodes it to binary and
// checks that each sample holds or advances by exactly one (mod 2^WIDTH).
//   Clk      : clock, posedge
//   Reset    : async active-low reset
//   En       : sample strobe
//   Clr      : sync clear of Error/Overflow, forces resync
//   Gray     : gray-coded count from transmitter
//   Count    : registered binary of last accepted sample
//   Valid    : high while tracking a legal sequence
//   Step     : one-cycle pulse per accepted +1 advance
//   Overflow : sticky, set on accepted wrap from max to 0
//   Error    : sticky, set on an illegal transition
module gray_rx
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Clr,
    input  logic [WIDTH-1:0] Gray,
    output logic [WIDTH-1:0] Count,
    output logic             Valid,
    output logic             Step,
    output logic             Overflow,
    output logic             Error
);

    localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};

    rx_state_t        state_q, state_d;
    logic [WIDTH-1:0] count_d;
    logic             valid_d, step_d, overflow_d, error_d;
    logic [WIDTH-1:0] bin_c;
    logic [WIDTH-1:0] next_count_c;

    gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
        .gray (Gray),
        .bin  (bin_c)
    );

    // Wrapped +1: carry-out is dropped so max+1 compares equal to 0.
    assign next_count_c = Count + WIDTH'(1);

    // State and output registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= SYNC;
            Count    <= '0;
            Valid    <= 1'b0;
            Step     <= 1'b0;
            Overflow <= 1'b0;
            Error    <= 1'b0;
        end else begin
            state_q  <= state_d;
            Count    <= count_d;
            Valid    <= valid_d;
            Step     <= step_d;
            Overflow <= overflow_d;
            Error    <= error_d;
        end
    end

    // Next-state and next-output logic; Clr overrides any sample on its edge.
    always_comb begin
        state_d    = state_q;
        count_d    = Count;
        valid_d    = Valid;
        step_d     = 1'b0;
        overflow_d = Overflow;
        error_d    = Error;

        if (Clr) begin
            state_d    = SYNC;
            valid_d    = 1'b0;
            overflow_d = 1'b0;
            error_d    = 1'b0;
        end else begin
            case (state_q)
                SYNC: begin
                    // First sample after reset/clear is trusted unconditionally.
                    if (En) begin
                        count_d = bin_c;
                        valid_d = 1'b1;
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (En) begin
                        if (bin_c == next_count_c) begin
                            count_d = bin_c;
                            step_d  = 1'b1;
                            if (Count == COUNT_MAX) begin
                                overflow_d = 1'b1;
                            end
                        end else if (bin_c != Count) begin
                            error_d = 1'b1;
                            valid_d = 1'b0;
                            state_d = ERR;
                        end
                    end
                end
                ERR: begin
                    valid_d = 1'b0;
                    error_d = 1'b1;
                end
                default: begin
                    state_d = SYNC;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_rx.sv
// Randomised and directed check of gray_rx against a behavioural model that
// works on intended binary counts; Gray is produced by encoding b ^ (b >> 1).
module tb_gray_rx;

    localparam int unsigned W   = 3;
    localparam int          MOD = 1 << W;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         clr;
    logic [W-1:0] gray;
    logic [W-1:0] count;
    logic         valid, step, overflow, error;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: 0 = awaiting first sample, 1 = tracking, 2 = stuck on error.
    int m_mode, m_count;
    bit m_valid, m_step, m_ovf, m_err;

    gray_rx #(.WIDTH(W)) dut (
        .Clk      (clk),
        .Reset    (rst_n),
        .En       (en),
        .Clr      (clr),
        .Gray     (gray),
        .Count    (count),
        .Valid    (valid),
        .Step     (step),
        .Overflow (overflow),
        .Error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"},    int'(count),    m_count);
        check({tag, ".valid"},    int'(valid),    int'(m_valid));
        check({tag, ".step"},     int'(step),     int'(m_step));
        check({tag, ".overflow"}, int'(overflow), int'(m_ovf));
        check({tag, ".error"},    int'(error),    int'(m_err));
    endtask

    task automatic model_reset();
        m_mode = 0; m_count = 0;
        m_valid = 0; m_step = 0; m_ovf = 0; m_err = 0;
    endtask

    // One clock with the given strobe, clear and intended binary value b.
    task automatic apply(input bit e, input bit c, input int b, input string tag);
        int bb;
        bb   = b % MOD;
        en   = e;
        clr  = c;
        gray = W'(bb ^ (bb >> 1));
        @(posedge clk);
        #1;
        m_step = 0;
        if (c) begin
            m_mode = 0; m_valid = 0; m_ovf = 0; m_err = 0;
        end else if (e) begin
            if (m_mode == 0) begin
                m_count = bb; m_valid = 1; m_mode = 1;
            end else if (m_mode == 1) begin
                if (bb == (m_count + 1) % MOD) begin
                    if (m_count == MOD - 1) m_ovf = 1;
                    m_count = bb;
                    m_step  = 1;
                end else if (bb != m_count) begin
                    m_err = 1; m_valid = 0; m_mode = 2;
                end
            end
        end
        check_all(tag);
    endtask

    // Pull reset between edges and confirm outputs clear before any clock.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int seq[10];
        int r, k, b;
        bit e, c;

        rst_n = 1'b0; en = 1'b0; clr = 1'b0; gray = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // Full forward sequence including wrap.
        seq = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 0};
        foreach (seq[i]) apply(1, 0, seq[i], "fwd");

        // Illegal jump from 1 to 3, then ERR ignores further samples.
        apply(1, 0, 1, "to1");
        apply(1, 0, 3, "jump");
        for (int i = 0; i < 3; i++) apply(1, 0, $urandom_range(0, MOD - 1), "err_hold");

        // Clear with a simultaneous sample discards it; next sample reloads.
        apply(1, 1, 4, "clr");
        apply(1, 0, 4, "reload");

        // En gating: illegal value with En low changes nothing.
        apply(1, 1, 0, "clr2");
        apply(1, 0, 2, "load2");
        apply(0, 0, 6, "gated");
        apply(1, 0, 3, "after_gate");

        // Reach count 5 with Overflow set, then async reset mid-run.
        for (int v = 4; v <= 13; v++) apply(1, 0, v, "climb");
        async_reset("async");
        apply(1, 0, 6, "post_rst");

        // Randomised traffic biased toward legal holds and advances.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 149) == 0) async_reset("rnd_rst");
            r = int'($urandom_range(0, 99));
            c = (r < 4);
            e = (r % 3 != 0);
            k = int'($urandom_range(0, 9));
            if (k < 4)      b = m_count;
            else if (k < 9) b = m_count + 1;
            else            b = int'($urandom_range(0, MOD - 1));
            apply(e, c, b, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
